// File: rtl/pea_core.sv
// Polynomial evaluation accelerator core: latches commands, stores coefficient sets
// and evaluates them by Horner's rule, emitting paired result/status tokens.
module pea_core #(
    parameter int buffer_size = 1024,
    parameter int width       = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [width-1:0]               data_in_fifo_command,
    input  logic [width-1:0]               data_in_fifo_data,
    input  logic                           invoke,
    input  logic [1:0]                     next_instr,
    input  logic [$clog2(buffer_size)-1:0] data_pop,
    input  logic [$clog2(buffer_size)-1:0] command_pop,
    output logic                           rd_in_command,
    output logic                           rd_in_data,
    output logic                           FC,
    output logic                           wr_out,
    output logic [2*width-1:0]             data_out_result,
    output logic [2*width-1:0]             data_out_status,
    output logic [7:0]                     instr,
    output logic [4:0]                     arg2
);
    typedef enum logic [2:0] {
        IDLE, GC_RD, GC_LATCH, EX_RD, EX_LOAD, EX_CALC, EX_WR, DONE
    } state_t;

    typedef struct packed {
        logic [7:0] op;
        logic [2:0] a;
        logic [4:0] arg;
    } cmd_t;

    localparam logic [1:0] MODE_GC    = 2'b00;
    localparam logic [1:0] MODE_INSTR = 2'b01;

    state_t                     state_q, state_d;
    cmd_t                       cmd;
    logic [2:0]                 a_q;
    logic [7:0]                 valid_q;
    logic [3:0]                 deg_q [8];
    logic signed [15:0]         coef [8][11];
    logic [3:0]                 k_q, k_m1;
    logic [4:0]                 xcnt_q;
    logic signed [2*width-1:0]  acc_q, x_q;
    logic [2*width-1:0]         status_q;
    logic                       is_stp, is_evp, is_rst, stp_ok, evp_ok, go_rd, no_tok;
    logic                       unused_pops;

    assign unused_pops = ^{data_pop, command_pop};
    assign cmd    = data_in_fifo_command;
    assign k_m1   = k_q - 4'd1;
    assign is_stp = (instr == 8'd1);
    assign is_evp = (instr == 8'd2);
    assign is_rst = (instr == 8'd3);
    assign stp_ok = (arg2 <= 5'd10);
    assign evp_ok = is_evp && valid_q[a_q];
    assign go_rd  = (is_stp && stp_ok) || (evp_ok && arg2 != 5'd0);
    assign no_tok = evp_ok && arg2 == 5'd0;

    assign data_out_result = acc_q;
    assign data_out_status = status_q;

    always_comb begin
        state_d       = state_q;
        rd_in_command = 1'b0;
        rd_in_data    = 1'b0;
        wr_out        = 1'b0;
        FC            = 1'b0;
        case (state_q)
            IDLE: if (invoke) begin
                if (next_instr == MODE_GC)         state_d = GC_RD;
                else if (next_instr == MODE_INSTR) state_d = go_rd ? EX_RD : (no_tok ? DONE : EX_WR);
                else                               state_d = DONE;
            end
            GC_RD: begin
                rd_in_command = 1'b1;
                state_d       = GC_LATCH;
            end
            GC_LATCH: state_d = DONE;
            EX_RD: begin
                rd_in_data = 1'b1;
                state_d    = EX_LOAD;
            end
            EX_LOAD: begin
                if (is_stp) state_d = (k_q == arg2[3:0]) ? EX_WR : EX_RD;
                else        state_d = (deg_q[a_q] == 4'd0) ? EX_WR : EX_CALC;
            end
            EX_CALC: if (k_q == 4'd1) state_d = EX_WR;
            EX_WR: begin
                wr_out  = 1'b1;
                state_d = (evp_ok && xcnt_q > 5'd1) ? EX_RD : DONE;
            end
            DONE: begin
                FC      = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            instr    <= '0;
            arg2     <= '0;
            a_q      <= '0;
            valid_q  <= '0;
            k_q      <= '0;
            xcnt_q   <= '0;
            acc_q    <= '0;
            x_q      <= '0;
            status_q <= '0;
            for (int i = 0; i < 8; i++) deg_q[i] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (invoke && next_instr == MODE_INSTR) begin
                    k_q    <= '0;
                    xcnt_q <= arg2;
                    // Error / single-token outcomes are decided up front; the
                    // STP and EVP data paths fill acc/status later.
                    if (is_stp && !stp_ok) begin
                        acc_q <= '0; status_q <= 32'd2;
                    end else if (is_evp && !valid_q[a_q]) begin
                        acc_q <= '0; status_q <= 32'd1;
                    end else if (is_rst) begin
                        valid_q[a_q] <= 1'b0;
                        acc_q <= '0; status_q <= 32'd0;
                    end else if (!is_stp && !is_evp) begin
                        acc_q <= '0; status_q <= 32'd3;
                    end
                end
                GC_LATCH: begin
                    instr <= cmd.op;
                    a_q   <= cmd.a;
                    arg2  <= cmd.arg;
                end
                EX_LOAD: begin
                    if (is_stp) begin
                        k_q <= k_q + 4'd1;
                        if (k_q == arg2[3:0]) begin
                            valid_q[a_q] <= 1'b1;
                            deg_q[a_q]   <= arg2[3:0];
                            acc_q        <= 32'(arg2) + 32'd1;
                            status_q     <= '0;
                        end
                    end else begin
                        x_q      <= 32'(signed'(data_in_fifo_data));
                        acc_q    <= 32'(coef[a_q][deg_q[a_q]]);
                        k_q      <= deg_q[a_q];
                        status_q <= '0;
                    end
                end
                EX_CALC: begin
                    acc_q <= acc_q * x_q + 32'(coef[a_q][k_m1]);
                    k_q   <= k_m1;
                end
                EX_WR: if (evp_ok) xcnt_q <= xcnt_q - 5'd1;
                default: ;
            endcase
        end
    end

    // Coefficient storage carries no reset; valid_q alone qualifies it.
    always_ff @(posedge clk) begin
        if (rst && state_q == EX_LOAD && is_stp)
            coef[a_q][k_q] <= signed'(data_in_fifo_data);
    end
endmodule

// File: tb/tb_pea_core.sv
// Directed bench for pea_core: behavioural FIFOs, token capture and latency checks.
module tb_pea_core;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] data_in_fifo_command = '0;
    logic [15:0] data_in_fifo_data = '0;
    logic        invoke = 1'b0;
    logic [1:0]  next_instr = 2'b00;
    logic [9:0]  data_pop = '0;
    logic [9:0]  command_pop = '0;
    logic        rd_in_command, rd_in_data, FC, wr_out;
    logic [31:0] data_out_result, data_out_status;
    logic [7:0]  instr;
    logic [4:0]  arg2;

    logic [15:0] cmd_q[$];
    logic [15:0] dat_q[$];
    logic [31:0] res_q[$];
    logic [31:0] st_q[$];
    int n_chk = 0, n_err = 0;
    int n_rd_data = 0, n_wr = 0, n_fc = 0, n_b2b = 0, n_ovl = 0;
    logic prev_rd = 1'b0;

    pea_core dut (
        .clk(clk), .rst(rst),
        .data_in_fifo_command(data_in_fifo_command),
        .data_in_fifo_data(data_in_fifo_data),
        .invoke(invoke), .next_instr(next_instr),
        .data_pop(data_pop), .command_pop(command_pop),
        .rd_in_command(rd_in_command), .rd_in_data(rd_in_data),
        .FC(FC), .wr_out(wr_out),
        .data_out_result(data_out_result), .data_out_status(data_out_status),
        .instr(instr), .arg2(arg2)
    );

    always #5 clk = ~clk;

    // Registered-read FIFOs: strobe at edge t, head valid for the DUT at edge t+1.
    always @(posedge clk) begin
        if (rd_in_command && cmd_q.size() > 0) data_in_fifo_command <= cmd_q.pop_front();
        if (rd_in_data && dat_q.size() > 0)    data_in_fifo_data <= dat_q.pop_front();
        command_pop <= 10'(cmd_q.size());
        data_pop    <= 10'(dat_q.size());
    end

    always @(negedge clk) begin
        if (rst) begin
            if (rd_in_data) n_rd_data <= n_rd_data + 1;
            if (FC) n_fc <= n_fc + 1;
            if (FC && wr_out) n_ovl <= n_ovl + 1;
            if ((rd_in_data || rd_in_command) && prev_rd) n_b2b <= n_b2b + 1;
            if (wr_out) begin
                n_wr <= n_wr + 1;
                res_q.push_back(data_out_result);
                st_q.push_back(data_out_status);
            end
        end
        prev_rd <= rd_in_data || rd_in_command;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic chk_zero_out(input string tag);
        chk({tag, "_rdc"}, 32'(rd_in_command), 32'd0);
        chk({tag, "_rdd"}, 32'(rd_in_data), 32'd0);
        chk({tag, "_fc"}, 32'(FC), 32'd0);
        chk({tag, "_wr"}, 32'(wr_out), 32'd0);
        chk({tag, "_res"}, data_out_result, 32'd0);
        chk({tag, "_st"}, data_out_status, 32'd0);
        chk({tag, "_instr"}, 32'(instr), 32'd0);
        chk({tag, "_arg2"}, 32'(arg2), 32'd0);
    endtask

    // Fire one invoke; lat is the cycle (after the invoke edge) in which FC shows.
    task automatic fire(input logic [1:0] mode, output int lat);
        @(posedge clk); #1;
        invoke = 1'b1; next_instr = mode;
        @(posedge clk); #1;
        invoke = 1'b0; lat = 1;
        while (!FC && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!FC) chk("fc_timeout", 32'(FC), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic gc(input logic [15:0] c);
        int lat;
        cmd_q.push_back(c);
        fire(2'b00, lat);
    endtask

    task automatic do_instr(input string tag, input int e_pops, input int e_wr, input int e_lat);
        int p0, w0, lat;
        p0 = n_rd_data; w0 = n_wr;
        fire(2'b01, lat);
        chk({tag, "_pops"}, 32'(n_rd_data - p0), 32'(e_pops));
        chk({tag, "_ntok"}, 32'(n_wr - w0), 32'(e_wr));
        chk({tag, "_lat"}, 32'(lat), 32'(e_lat));
    endtask

    task automatic chk_tok(input string tag, input logic [31:0] er, input logic [31:0] es);
        chk({tag, "_have"}, 32'(res_q.size() > 0), 32'd1);
        if (res_q.size() > 0) begin
            chk({tag, "_res"}, res_q.pop_front(), er);
            chk({tag, "_st"}, st_q.pop_front(), es);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int fc0, lat;
        repeat (3) @(posedge clk);
        #1 chk_zero_out("rst");
        rst = 1'b1;

        // GC 0x0102: exact latency of strobe, latch and FC
        cmd_q.push_back(16'h0102);
        @(posedge clk); #1; invoke = 1'b1; next_instr = 2'b00;
        @(posedge clk); #1; invoke = 1'b0;
        chk("gc_rd_c1", 32'(rd_in_command), 32'd1);
        chk("gc_fc_c1", 32'(FC), 32'd0);
        @(posedge clk); #1;
        chk("gc_rd_c2", 32'(rd_in_command), 32'd0);
        chk("gc_instr_pre", 32'(instr), 32'd0);
        @(posedge clk); #1;
        chk("gc_instr", 32'(instr), 32'd1);
        chk("gc_arg2", 32'(arg2), 32'd2);
        chk("gc_fc_c3", 32'(FC), 32'd1);
        @(posedge clk); #1;
        chk("gc_fc_c4", 32'(FC), 32'd0);
        chk("gc_nowr", 32'(n_wr), 32'd0);

        // STP A=0: c0=3 c1=2 c2=1
        dat_q.push_back(16'd3); dat_q.push_back(16'd2); dat_q.push_back(16'd1);
        do_instr("stp0", 3, 1, 8);
        chk_tok("stp0", 32'd3, 32'd0);

        // EVP A=0 x=2 -> 1*4 + 2*2 + 3
        gc(16'h0201);
        dat_q.push_back(16'd2);
        do_instr("evp0", 1, 1, 6);
        chk_tok("evp0", 32'd11, 32'd0);

        // EVP A=0 x=-1 -> 2, x=3 -> 18
        gc(16'h0202);
        dat_q.push_back(16'hFFFF); dat_q.push_back(16'd3);
        do_instr("evp2", 2, 2, 11);
        chk_tok("evp2a", 32'd2, 32'd0);
        chk_tok("evp2b", 32'd18, 32'd0);

        // Degree-0 polynomial on A=2 holding -5
        gc(16'h0140);
        dat_q.push_back(16'hFFFB);
        do_instr("stp2", 1, 1, 4);
        chk_tok("stp2", 32'd1, 32'd0);
        gc(16'h0241);
        dat_q.push_back(16'd7);
        do_instr("evpd0", 1, 1, 4);
        chk_tok("evpd0", 32'hFFFF_FFFB, 32'd0);

        // Error tokens
        gc(16'h02A1);
        do_instr("undef", 0, 1, 2);
        chk_tok("undef", 32'd0, 32'd1);
        gc(16'h010C);
        do_instr("deg12", 0, 1, 2);
        chk_tok("deg12", 32'd0, 32'd2);
        gc(16'h0700);
        do_instr("badop", 0, 1, 2);
        chk_tok("badop", 32'd0, 32'd3);

        // No-token firings
        gc(16'h0200);
        do_instr("evpb0", 0, 0, 1);
        fc0 = n_wr;
        fire(2'b10, lat);
        chk("out_lat", 32'(lat), 32'd1);
        chk("out_ntok", 32'(n_wr - fc0), 32'd0);

        // RST A=0 then EVP A=0
        gc(16'h0300);
        do_instr("rst0", 0, 1, 2);
        chk_tok("rst0", 32'd0, 32'd0);
        gc(16'h0201);
        dat_q.push_back(16'd2);
        do_instr("evprst", 0, 1, 2);
        chk_tok("evprst", 32'd0, 32'd1);
        dat_q.delete();

        // Reset in the middle of an STP firing
        gc(16'h0122);
        dat_q.push_back(16'd4); dat_q.push_back(16'd5); dat_q.push_back(16'd6);
        @(posedge clk); #1; invoke = 1'b1; next_instr = 2'b01;
        @(posedge clk); #1; invoke = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        fc0 = n_fc;
        @(posedge clk); #1;
        chk_zero_out("midrst");
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("midrst_nofc", 32'(n_fc - fc0), 32'd0);
        dat_q.delete();

        // Reset also cleared the A=2 polynomial
        gc(16'h0241);
        dat_q.push_back(16'd7);
        do_instr("postrst", 0, 1, 2);
        chk_tok("postrst", 32'd0, 32'd1);

        chk("no_b2b_rd", 32'(n_b2b), 32'd0);
        chk("fc_wr_ovl", 32'(n_ovl), 32'd0);
        chk("stray_tok", 32'(res_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
